// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
// Garbage fill word, RV32 opcode/funct fields and loader states.
package imem_loader_pkg;

    localparam logic [31:0] GARBAGE_WORD = 32'hFFFF_FFFF;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_CUST0  = 7'b000_1011;
    localparam logic [6:0] OPC_CUST1  = 7'b010_1011;

    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_WGHT    = 3'b000;
    localparam logic [2:0] F3_ANN     = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_LOAD = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    function automatic logic [31:0] enc_lw(
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [11:0] imm
    );
        return {imm, rs1, F3_WORD, rd, OPC_LOAD};
    endfunction

    function automatic logic [31:0] enc_sw(
        input logic [4:0]  rs2,
        input logic [4:0]  rs1,
        input logic [11:0] imm
    );
        return {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory loader: scrubs the memory, streams a program in,
// then releases the core. One address counter serves fill and load.
module imem_loader #(
    parameter int PC_SIZE = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               mem_we,
    output logic [PC_SIZE-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               err,
    output logic [PC_SIZE:0]   word_count
);
    import imem_loader_pkg::*;

    state_t             state;
    state_t             state_nxt;
    logic [PC_SIZE-1:0] addr;
    logic [PC_SIZE-1:0] addr_nxt;
    logic [PC_SIZE:0]   cnt;
    logic [PC_SIZE:0]   cnt_nxt;
    logic               at_top;

    assign at_top = (addr == {PC_SIZE{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            addr  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        cnt_nxt   = cnt;
        mem_we    = 1'b0;
        mem_wdata = in_data;
        in_ready  = 1'b0;
        unique case (state)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) begin
                    state_nxt = ST_FILL;
                    addr_nxt  = '0;
                    cnt_nxt   = '0;
                end
            end
            ST_FILL: begin
                mem_we    = 1'b1;
                mem_wdata = GARBAGE_WORD;
                if (at_top) begin
                    state_nxt = ST_LOAD;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt  = addr + 1'b1;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_we  = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                    // A full memory without a last marker is an overflow;
                    // the counter parks at the top instead of wrapping.
                    if (in_last) begin
                        state_nxt = ST_RUN;
                    end else if (at_top) begin
                        state_nxt = ST_ERR;
                    end else begin
                        addr_nxt  = addr + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                addr_nxt  = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign mem_addr   = addr;
    assign cpu_hold   = (state != ST_RUN);
    assign done       = (state == ST_RUN);
    assign err        = (state == ST_ERR);
    assign word_count = cnt;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with PC_SIZE=3 (8-word memory).
// Shadows memory writes and checks outputs after each step.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [3:0]  word_count;

    int n_chk  = 0;
    int n_fail = 0;
    int wr_n   = 0;
    int base;
    logic [31:0] tbmem [8];
    logic [31:0] prog [9];

    imem_loader #(.PC_SIZE(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            tbmem[mem_addr] <= mem_wdata;
            wr_n <= wr_n + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_fill(input bit inject_start);
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            start = inject_start && (i == 3);
            #1;
            chk("fill_we", 32'(mem_we), 32'd1);
            chk("fill_addr", 32'(mem_addr), 32'(i));
            chk("fill_data", mem_wdata, 32'hFFFF_FFFF);
            chk("fill_rdy", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        start = 1'b0;
        #1;
        chk("load_rdy", 32'(in_ready), 32'd1);
        chk("load_hold", 32'(cpu_hold), 32'd1);
        chk("load_idle_we", 32'(mem_we), 32'd0);
    endtask

    task automatic send(input logic [31:0] d, input logic last,
                        input int exp_addr);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        #1;
        chk("send_we", 32'(mem_we), 32'd1);
        chk("send_addr", 32'(mem_addr), 32'(exp_addr));
        chk("send_data", mem_wdata, d);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        #1;
        chk("idle_we", 32'(mem_we), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        prog[0] = 32'h0000_2083;
        prog[1] = 32'h0040_2103;
        prog[2] = 32'h0080_2183;
        prog[3] = 32'h0020_800B;
        prog[4] = 32'h0031_902B;
        prog[5] = 32'h0030_2623;
        prog[6] = 32'h1111_1111;
        prog[7] = 32'h2222_2222;
        prog[8] = 32'h3333_3333;
        for (int i = 0; i < 8; i++) tbmem[i] = 32'h0;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        in_data = 32'h0; in_last = 1'b0;
        #12;
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_cnt", 32'(word_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_rdy", 32'(in_ready), 32'd0);
        chk("idle_hold", 32'(cpu_hold), 32'd1);

        // Fill then a 6-word program
        do_fill(1'b0);
        base = wr_n;
        for (int i = 0; i < 6; i++) send(prog[i], i == 5, i);
        #1;
        chk("p1_writes", 32'(wr_n - base), 32'd6);
        chk("p1_done", 32'(done), 32'd1);
        chk("p1_hold", 32'(cpu_hold), 32'd0);
        chk("p1_cnt", 32'(word_count), 32'd6);
        chk("p1_rdy", 32'(in_ready), 32'd0);
        for (int i = 0; i < 6; i++) chk("p1_mem", tbmem[i], prog[i]);
        chk("p1_mem6", tbmem[6], 32'hFFFF_FFFF);
        chk("p1_mem7", tbmem[7], 32'hFFFF_FFFF);

        // Restart from RUN; start during FILL is ignored
        do_fill(1'b1);
        base = wr_n;
        send(prog[6], 1'b0, 0);
        idle_cycle();
        idle_cycle();
        send(prog[7], 1'b0, 1);
        send(prog[8], 1'b1, 2);
        #1;
        chk("p2_writes", 32'(wr_n - base), 32'd3);
        chk("p2_cnt", 32'(word_count), 32'd3);
        chk("p2_done", 32'(done), 32'd1);
        chk("p2_mem0", tbmem[0], prog[6]);
        chk("p2_mem1", tbmem[1], prog[7]);
        chk("p2_mem2", tbmem[2], prog[8]);
        chk("p2_mem3", tbmem[3], 32'hFFFF_FFFF);

        // Overflow: 9 words, no last; start with first word is ignored
        do_fill(1'b0);
        base = wr_n;
        start = 1'b1;
        send(prog[0], 1'b0, 0);
        start = 1'b0;
        #1;
        chk("p3_still_load", 32'(in_ready), 32'd1);
        for (int i = 1; i < 8; i++) send(prog[i], 1'b0, i);
        in_valid = 1'b1;
        in_data  = prog[8];
        #1;
        chk("p3_rdy", 32'(in_ready), 32'd0);
        chk("p3_we", 32'(mem_we), 32'd0);
        chk("p3_err", 32'(err), 32'd1);
        chk("p3_done", 32'(done), 32'd0);
        chk("p3_hold", 32'(cpu_hold), 32'd1);
        chk("p3_cnt", 32'(word_count), 32'd8);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("p3_writes", 32'(wr_n - base), 32'd8);
        chk("p3_mem7", tbmem[7], prog[7]);
        chk("p3_err_hold", 32'(err), 32'd1);

        // Reset mid-load at count 3
        do_fill(1'b0);
        chk("p4_err_clr", 32'(err), 32'd0);
        base = wr_n;
        for (int i = 0; i < 3; i++) send(prog[i], 1'b0, i);
        chk("p4_cnt3", 32'(word_count), 32'd3);
        in_valid = 1'b1;
        in_data  = prog[3];
        #1;
        chk("p4_we_pre", 32'(mem_we), 32'd1);
        chk("p4_addr_pre", 32'(mem_addr), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("p4_rst_we", 32'(mem_we), 32'd0);
        chk("p4_rst_rdy", 32'(in_ready), 32'd0);
        chk("p4_rst_hold", 32'(cpu_hold), 32'd1);
        chk("p4_rst_cnt", 32'(word_count), 32'd0);
        chk("p4_rst_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        chk("p4_writes", 32'(wr_n - base), 32'd3);
        @(negedge clk);
        #1;
        chk("p4_idle_rdy", 32'(in_ready), 32'd0);
        chk("p4_idle_done", 32'(done), 32'd0);

        // New start after reset reloads from address 0
        do_fill(1'b0);
        send(prog[4], 1'b0, 0);
        send(prog[5], 1'b1, 1);
        #1;
        chk("p5_done", 32'(done), 32'd1);
        chk("p5_cnt", 32'(word_count), 32'd2);
        chk("p5_mem0", tbmem[0], prog[4]);
        chk("p5_mem1", tbmem[1], prog[5]);
        chk("p5_mem2", tbmem[2], 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter PC_SIZE, default 8: instruction-memory address width; depth N = 2^PC_SIZE words.
REQ-002 SHALL have `clk`, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have `rst_n`, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have `start`, input, 1: single-cycle request to (re)program the memory.
REQ-005 SHALL have `in_valid`, input, 1: a program word is offered.
REQ-006 SHALL have `in_data`, input, 32: the offered instruction word.
REQ-007 SHALL have `in_last`, input, 1: the offered word is the final word of the program.
REQ-008 SHALL have `in_ready`, output, 1: the loader accepts the word this cycle.
REQ-009 SHALL have `mem_we`, output, 1: instruction-memory write enable.
REQ-010 SHALL have `mem_addr`, output, PC_SIZE: instruction-memory write address.
REQ-011 SHALL have `mem_wdata`, output, 32: instruction-memory write data.
REQ-012 SHALL have `cpu_hold`, output, 1: holds the processor (fetch PC at 0, no retire) while high.
REQ-013 SHALL have `done`, output, 1: the program loaded and the processor is released.
REQ-014 SHALL have `err`, output, 1: the program overflowed memory depth.
REQ-015 SHALL have `word_count`, output, PC_SIZE+1: number of program words written in the last load.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, LOAD, RUN, ERR.
REQ-017 IDLE SHALL go to FILL on `start`=1; otherwise IDLE holds.
REQ-018 FILL SHALL write the garbage word to address a, for a = 0..N-1 in order, one per cycle (`mem_we`=1, `in_ready`=0), taking exactly N cycles.
REQ-019 FILL SHALL go to LOAD on the cycle after the write to N-1, with the address counter cleared to 0.
REQ-020 In LOAD, `in_ready` SHALL be 1, and a word SHALL be accepted on any cycle with `in_valid`=1.
REQ-021 In LOAD, an accepted word SHALL be written combinationally on the same cycle (`mem_we`=1, `mem_addr`=count, `mem_wdata`=`in_data`), and then count SHALL increment.
REQ-022 In LOAD, `mem_we` SHALL be 0 when `in_valid`=0, and count SHALL hold.
REQ-023 In LOAD, an accepted word with `in_last`=1 SHALL go to RUN; `word_count` SHALL then equal the number of words written (1..N).
REQ-024 In LOAD, an accepted word at address N-1 with `in_last`=0 SHALL be written, and the FSM SHALL then go to ERR with `word_count`=N; the counter SHALL NOT wrap.
REQ-025 `cpu_hold` SHALL be 0 only in RUN; `done` SHALL be 1 only in RUN; `err` SHALL be 1 only in ERR.
REQ-026 RUN and ERR SHALL go to FILL on `start`=1, clearing `done`/`err` and `word_count` on entry.
REQ-027 `start` in FILL or LOAD SHALL be ignored.
REQ-028 `start` and an accepted word on the same LOAD cycle SHALL result in the word being processed and `start` ignored.
REQ-029 Outside FILL and LOAD, `mem_we` SHALL be 0 and `in_ready` SHALL be 0.

Reset
REQ-030 Asserting `rst_n`=0 SHALL immediately, at any time including mid-FILL/LOAD, force state IDLE, address counter 0 and `word_count` 0.
REQ-031 During and after reset, outputs SHALL be `cpu_hold`=1, `done`=0, `err`=0, `mem_we`=0 and `in_ready`=0.
REQ-032 Memory contents after reset mid-load SHALL be undefined; a new `start` SHALL be required.

Structure
REQ-033 A shared package SHALL hold the garbage word constant 32'hFFFFFFFF, the opcode/funct constants and the FSM state encoding.
REQ-034 The block SHALL be a single module with no sub-module; the address counter SHALL be shared by FILL and LOAD.

Verification (PC_SIZE=3, N=8)
REQ-035 Reset, then `start` -> 8 consecutive writes of FFFFFFFF to addresses 0..7, then `in_ready`=1, `cpu_hold`=1.
REQ-036 Load 6 words (lw, lw, lw, wght, ann, sw encodings) with `in_last` on the 6th -> addresses 0..5 written in order, `done`=1, `cpu_hold`=0, `word_count`=6, addresses 6..7 = FFFFFFFF.
REQ-037 `in_valid` toggled 1,0,0,1,1 (last on the 5th cycle) -> exactly 3 writes to addresses 0,1,2, with no write on idle cycles.
REQ-038 9 words with no `in_last` -> 8 writes, `err`=1, `word_count`=8, `in_ready`=0 on the 9th word, `cpu_hold`=1.
REQ-039 `rst_n` low during LOAD at count 3 -> IDLE immediately, `mem_we`=0; `start` while in RUN -> refill and reload from address 0.
